spi_core: RTL and testbench
===========================

Name: spi_core

Overview:
- Serial engine behind the APB4 SPI register block, which owns the NSS, TX FIFO and RX FIFO.
- Pops words from the TX FIFO, shifts them out on a single-lane SPI bus and shifts return data in.
- Pushes each received word into the RX FIFO.
- Reports busy/last so the register block can freeze configuration and clear the start bit.

Parameters:
TRL_WIDTH, 16, width of transfer-length (word count) input.

Ports:
clk_i  in  1  system clock (APB pclk).
rst_n_i  in  1  reset.
st_i  in  1  start request (level; ctrl ST bit).
cpol_i  in  1  clock polarity.
cpha_i  in  1  clock phase.
lsb_i  in  1  1 = LSB-first.
div_i  in  8  SCK half-period = div_i+1 clk cycles.
dsize_i  in  2  word size: 0=8, 1=16, 2=24, 3=32 bits.
trl_i  in  TRL_WIDTH  words per transfer.
busy_o  out  1  transfer in progress.
last_o  out  1  one-cycle end-of-transfer pulse.
tx_valid_i  in  1  TX FIFO non-empty.
tx_ready_o  out  1  TX pop strobe.
tx_data_i  in  32  TX word, right-aligned.
rx_valid_o  out  1  RX word available.
rx_ready_i  in  1  RX FIFO not full.
rx_data_o  out  32  RX word, right-aligned, zero-extended.
spi_sck_o  out  1  serial clock.
spi_io_en_o  out  4  pad output enables.
spi_io_out_o  out  4  pad outputs; [0]=MOSI.
spi_io_in_i  in  4  pad inputs; [1]=MISO.

Behaviour:
- Interface (decided): one clock clk_i; reset rst_n_i is asynchronous, active-low.
- Reset/idle values:
  - busy_o=0, last_o=0, tx_ready_o=0, rx_valid_o=0.
  - rx_data_o=0, spi_io_out_o=0, spi_io_en_o=0.
  - spi_sck_o=0 at reset; spi_sck_o=latched cpol in IDLE thereafter.
  - Reset mid-transfer aborts immediately to these values; no partial word is pushed.
- FSM states: IDLE, LOAD, SHIFT, STORE, DONE.
  - IDLE: on st_i=1, latch cpol/cpha/lsb/div/dsize/trl.
    - trl_i=0 -> DONE.
    - Otherwise -> LOAD, word counter = trl_i.
  - LOAD: while tx_valid_i=0, wait with SCK held at cpol.
    - When tx_valid_i=1: tx_ready_o=1 for exactly that cycle; load shift register; bit counter = 8*(dsize+1); -> SHIFT.
  - SHIFT: divider counts 0..div; every div+1 cycles SCK toggles, alternating leading/trailing edges.
    - cpha=0: first bit on MOSI on SHIFT entry; sample MISO on leading edge; next bit on trailing edge.
    - cpha=1: drive bit on leading edge; sample on trailing edge.
    - After the trailing edge of the final bit (2*n*(div+1) cycles, n = bits), SCK = cpol -> STORE.
  - STORE: rx_valid_o=1, rx_data_o stable until rx_ready_i=1 (push on valid&ready).
    - Decrement word counter; counter 0 -> DONE, else -> LOAD.
  - DONE: last_o=1 and busy_o=1 for one cycle -> IDLE.
    - The register block clears ST on that edge, so IDLE never restarts from a stale st_i.
- busy_o = (state != IDLE); spi_io_en_o = 4'b0001 while busy, else 0.
- Bit order:
  - MSB-first transmits bit n-1 down to 0; received first bit lands in bit n-1.
  - LSB-first is the mirror.
  - tx_data_i bits above n are ignored; rx_data_o bits above n are 0.
- Config inputs are ignored while busy; the latched copy is used.
- MOSI holds its last bit between words and returns to 0 in IDLE.

Test Plan:
1. cpol=0, cpha=0, MSB, div=0, dsize=0, trl=1, tx 0xA5, MISO looped to MOSI -> 8 SCK pulses, period 2 clk; MOSI 1,0,1,0,0,1,0,1; rx_data_o=0x000000A5; single last_o pulse; busy drops next cycle.
2. lsb=1, dsize=1, tx 0x1234, MISO tied 1 -> MOSI first 8 bits 0,0,1,0,1,1,0,0; 16 pulses; rx_data_o=0x0000FFFF.
3. cpol=1, cpha=1, div=3, dsize=3, tx 0xDEADBEEF loopback -> SCK idles 1, half-period 4 clk; 256 SHIFT cycles; rx_data_o=0xDEADBEEF.
4. trl=3; tx_valid low 10 cycles before word 2; rx_ready low 5 cycles on word 1 -> SCK frozen at cpol during stalls; rx_valid/data held stable; exactly 3 pops, 3 pushes, then last.
5. st_i=1 with trl=0 -> DONE after 1 cycle; last_o one cycle; no SCK edge; no tx pop.
6. rst_n_i low mid-word of test 3 -> all outputs at reset values in the same cycle; no rx push; a new start afterwards completes normally.

Source files
------------

// File: rtl/spi_core.sv
// Single-lane SPI serial engine: pops TX words, shifts them out on MOSI,
// collects MISO into RX words and pushes them, sequenced by a small FSM.
module spi_core #(
    parameter int TRL_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 st_i,
    input  logic                 cpol_i,
    input  logic                 cpha_i,
    input  logic                 lsb_i,
    input  logic [7:0]           div_i,
    input  logic [1:0]           dsize_i,
    input  logic [TRL_WIDTH-1:0] trl_i,
    output logic                 busy_o,
    output logic                 last_o,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    input  logic [31:0]          tx_data_i,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic [31:0]          rx_data_o,
    output logic                 spi_sck_o,
    output logic [3:0]           spi_io_en_o,
    output logic [3:0]           spi_io_out_o,
    input  logic [3:0]           spi_io_in_i
);

    // state | meaning
    // IDLE  | waiting for st_i, SCK parked at latched cpol, MOSI low
    // LOAD  | waiting for a TX word; pops it and primes the shifter
    // SHIFT | toggling SCK every div+1 cycles, moving bits both ways
    // STORE | presenting the received word until the RX FIFO accepts it
    // DONE  | one-cycle end-of-transfer pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_STORE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic                 cpol_q;
    logic                 cpha_q;
    logic                 lsb_q;
    logic [7:0]           div_q;
    logic [1:0]           dsize_q;
    logic [TRL_WIDTH-1:0] word_cnt;
    logic [6:0]           edge_cnt;
    logic [7:0]           div_cnt;
    logic                 sck_q;
    logic                 mosi_q;
    logic [31:0]          tx_sh;
    logic [31:0]          rx_sh;
    logic [31:0]          rx_data_q;

    logic        sck_edge;
    logic        lead_edge;
    logic        trail_edge;
    logic        final_edge;
    logic        sample_now;
    logic        drive_now;
    logic        miso;
    logic [4:0]  pad_bits;
    logic [31:0] tx_aligned;
    logic [31:0] rx_shifted;
    logic [31:0] rx_next;
    logic [31:0] rx_aligned;
    logic        unused_io_in;

    assign unused_io_in = ^{spi_io_in_i[3:2], spi_io_in_i[0]};
    assign miso         = spi_io_in_i[1];

    // Number of unused upper bits in a 32-bit word for the latched word size.
    assign pad_bits = {~dsize_q, 3'b000};

    assign sck_edge   = (state == S_SHIFT) && (div_cnt == 8'd0);
    assign lead_edge  = sck_edge && (sck_q == cpol_q);
    assign trail_edge = sck_edge && (sck_q != cpol_q);
    assign final_edge = sck_edge && (edge_cnt == 7'd1);
    assign sample_now = cpha_q ? trail_edge : lead_edge;
    // With cpha=0 the last trailing edge drives nothing so MOSI keeps the last bit.
    assign drive_now  = cpha_q ? lead_edge : (trail_edge && !final_edge);

    // MSB-first words are left-aligned so the outgoing bit is always [31];
    // LSB-first words stay right-aligned and leave from [0].
    assign tx_aligned = lsb_q ? tx_data_i : (tx_data_i << pad_bits);
    assign rx_shifted = lsb_q ? {miso, rx_sh[31:1]} : {rx_sh[30:0], miso};
    assign rx_next    = sample_now ? rx_shifted : rx_sh;
    assign rx_aligned = lsb_q ? (rx_next >> pad_bits) : rx_next;

    function automatic logic out_bit(input logic lsb, input logic [31:0] v);
        return lsb ? v[0] : v[31];
    endfunction

    function automatic logic [31:0] shift_word(input logic lsb, input logic [31:0] v);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy_o     = 1'b1;
        last_o     = 1'b0;
        tx_ready_o = 1'b0;
        rx_valid_o = 1'b0;
        case (state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (st_i) begin
                    state_nxt = (trl_i == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                tx_ready_o = tx_valid_i;
                if (tx_valid_i) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (final_edge) begin
                    state_nxt = S_STORE;
                end
            end
            S_STORE: begin
                rx_valid_o = 1'b1;
                if (rx_ready_i) begin
                    state_nxt = (word_cnt == TRL_WIDTH'(1)) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                last_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            div_q     <= 8'd0;
            dsize_q   <= 2'd0;
            word_cnt  <= '0;
            edge_cnt  <= 7'd0;
            div_cnt   <= 8'd0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            tx_sh     <= 32'd0;
            rx_sh     <= 32'd0;
            rx_data_q <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    mosi_q <= 1'b0;
                    sck_q  <= cpol_q;
                    if (st_i) begin
                        cpol_q   <= cpol_i;
                        cpha_q   <= cpha_i;
                        lsb_q    <= lsb_i;
                        div_q    <= div_i;
                        dsize_q  <= dsize_i;
                        word_cnt <= trl_i;
                        sck_q    <= cpol_i;
                    end
                end
                S_LOAD: begin
                    if (tx_valid_i) begin
                        edge_cnt <= {3'(dsize_q) + 3'd1, 4'b0000};
                        div_cnt  <= div_q;
                        rx_sh    <= 32'd0;
                        if (!cpha_q) begin
                            mosi_q <= out_bit(lsb_q, tx_aligned);
                            tx_sh  <= shift_word(lsb_q, tx_aligned);
                        end else begin
                            tx_sh  <= tx_aligned;
                        end
                    end
                end
                S_SHIFT: begin
                    rx_sh <= rx_next;
                    if (sck_edge) begin
                        sck_q    <= ~sck_q;
                        div_cnt  <= div_q;
                        edge_cnt <= edge_cnt - 7'd1;
                    end else begin
                        div_cnt  <= div_cnt - 8'd1;
                    end
                    if (drive_now) begin
                        mosi_q <= out_bit(lsb_q, tx_sh);
                        tx_sh  <= shift_word(lsb_q, tx_sh);
                    end
                    if (final_edge) begin
                        rx_data_q <= rx_aligned;
                    end
                end
                S_STORE: begin
                    if (rx_ready_i) begin
                        word_cnt <= word_cnt - TRL_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    mosi_q <= 1'b0;
                end
                default: begin
                    mosi_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data_o    = (state == S_STORE) ? rx_data_q : 32'd0;
    assign spi_sck_o    = sck_q;
    assign spi_io_out_o = {3'b000, mosi_q};
    assign spi_io_en_o  = {3'b000, busy_o};

endmodule

// File: tb/tb_spi_core.sv
// Directed bench for spi_core: TX FIFO model, RX scoreboard queue, SCK/MOSI monitor.
module tb_spi_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st, cpol, cpha, lsb;
    logic [7:0]  div;
    logic [1:0]  dsize;
    logic [15:0] trl;
    logic        busy, last, tx_valid, tx_ready, rx_valid, rx_ready;
    logic [31:0] tx_data, rx_data;
    logic        sck;
    logic [3:0]  io_en, io_out, io_in;

    logic [31:0] tx_mem [0:15];
    int          tx_idx = 0;
    int          tx_cnt = 0;
    logic        tx_stall = 1'b0;
    logic        miso_tied = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pops = 0, pushes = 0, lasts = 0, pulses = 0;
    int first_edge = -1, last_edge = -1;
    logic b_cpol = 1'b0, b_cpha = 1'b0;
    logic sck_prev = 1'b0, busy_prev = 1'b0;
    logic mosi_log [$];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    assign tx_valid = (tx_idx < tx_cnt) && !tx_stall;
    assign tx_data  = tx_mem[tx_idx[3:0]];
    assign io_in    = {2'b00, miso_tied ? 1'b1 : io_out[0], 1'b0};

    spi_core #(.TRL_WIDTH(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .st_i(st), .cpol_i(cpol), .cpha_i(cpha),
        .lsb_i(lsb), .div_i(div), .dsize_i(dsize), .trl_i(trl),
        .busy_o(busy), .last_o(last),
        .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_data_i(tx_data),
        .rx_valid_o(rx_valid), .rx_ready_i(rx_ready), .rx_data_o(rx_data),
        .spi_sck_o(sck), .spi_io_en_o(io_en), .spi_io_out_o(io_out), .spi_io_in_i(io_in)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // TX FIFO model: a pop seen at the negedge retires the word just after the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && tx_ready) begin
                pops++;
                @(posedge clk);
                #1 tx_idx++;
            end
        end
    end

    // RX scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            pushes++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_unexpected: got %0h want none", rx_data);
            end else begin
                chk("rx_data", {32'd0, rx_data}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    // SCK/MOSI monitor: counts leading edges, logs MOSI at each sampling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (last) lasts++;
            if (sck != sck_prev && busy && busy_prev) begin
                if (sck_prev == b_cpol) pulses++;
                if ((sck_prev == b_cpol) != b_cpha) mosi_log.push_back(io_out[0]);
                if (first_edge < 0) first_edge = cyc;
                last_edge = cyc;
            end
        end
        sck_prev  = sck;
        busy_prev = busy;
    end

    task automatic go(input logic cp, input logic ph, input logic lb, input logic [7:0] dv,
                      input logic [1:0] ds, input logic [15:0] tr);
        cpol = cp; cpha = ph; lsb = lb; div = dv; dsize = ds; trl = tr;
        b_cpol = cp; b_cpha = ph;
        pops = 0; pushes = 0; lasts = 0; pulses = 0;
        first_edge = -1; last_edge = -1;
        mosi_log.delete();
        st = 1'b1;
    endtask

    task automatic wait_last(output int n);
        n = 0;
        for (int i = 1; i <= 3000; i++) begin
            @(posedge clk);
            #1;
            if (last) begin
                n = i;
                break;
            end
        end
        st = 1'b0;
        if (n == 0) begin
            total++;
            bad++;
            $display("FAIL last_timeout: got none want last_o within 3000 cycles");
        end
    endtask

    task automatic push_tx(input logic [31:0] w);
        tx_mem[tx_cnt[3:0]] = w;
        tx_cnt++;
    endtask

    function automatic logic [7:0] log8();
        logic [7:0] v = 8'd0;
        for (int i = 0; i < 8 && i < mosi_log.size(); i++) v = {v[6:0], mosi_log[i]};
        return v;
    endfunction

    int n;
    logic seen;

    initial begin
        rst_n = 1'b0; st = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
        div = 8'd0; dsize = 2'd0; trl = 16'd0; rx_ready = 1'b1;
        #12;
        chk("reset_vals", {19'd0, busy, last, tx_ready, rx_valid, rx_data, io_out, io_en, sck}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: mode 0, MSB, div 0, 8-bit loopback; upper TX bits must be ignored
        miso_tied = 1'b0;
        push_tx(32'hFFFF_FFA5);
        exp_q.push_back(32'h0000_00A5);
        go(1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 16'd1);
        wait_last(n);
        @(posedge clk); #1;
        chk("t1_busy_drop", {last, busy, io_en, io_out, sck}, 64'd0);
        chk("t1_pulses", pulses, 8);
        chk("t1_mosi_bits", {mosi_log.size(), log8()}, {8, 8'hA5});
        chk("t1_span", last_edge - first_edge, 15);
        chk("t1_counts", {pops, pushes, lasts}, {32'd1, 32'd1, 32'd1});

        // 2: LSB-first 16-bit, MISO tied high
        miso_tied = 1'b1;
        push_tx(32'h0000_1234);
        exp_q.push_back(32'h0000_FFFF);
        go(1'b0, 1'b0, 1'b1, 8'd0, 2'd1, 16'd1);
        wait_last(n);
        @(posedge clk); #1;
        chk("t2_pulses", pulses, 16);
        chk("t2_mosi_first8", log8(), 8'h2C);
        chk("t2_counts", {pops, pushes, lasts}, {32'd1, 32'd1, 32'd1});
        miso_tied = 1'b0;

        // 3: mode 3, div 3, 32-bit loopback; config inputs scrambled while busy
        push_tx(32'hDEAD_BEEF);
        exp_q.push_back(32'hDEAD_BEEF);
        go(1'b1, 1'b1, 1'b0, 8'd3, 2'd3, 16'd1);
        @(posedge clk); #1;
        cpol = 1'b0; cpha = 1'b0; lsb = 1'b1; div = 8'd0; dsize = 2'd0; trl = 16'd5;
        wait_last(n);
        @(posedge clk); #1;
        chk("t3_pulses", pulses, 32);
        chk("t3_span", last_edge - first_edge, 63 * 4);
        chk("t3_idle", {busy, sck, io_en, io_out}, {1'b0, 1'b1, 4'd0, 4'd0});
        chk("t3_counts", {pops, pushes, lasts}, {32'd1, 32'd1, 32'd1});

        // 4: three words with RX back-pressure on word 1 and TX underrun before word 2
        push_tx(32'h11); push_tx(32'h22); push_tx(32'h33);
        exp_q.push_back(32'h11); exp_q.push_back(32'h22); exp_q.push_back(32'h33);
        go(1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 16'd3);
        fork
            wait_last(n);
            begin
                seen = 1'b0;
                for (int i = 0; i < 500; i++) begin
                    @(posedge clk); #1;
                    if (rx_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("t4_first_valid", seen, 1'b1);
                rx_ready = 1'b0;
                tx_stall = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(posedge clk); #1;
                    chk("t4_rx_stall", {rx_valid, sck, rx_data}, {1'b1, 1'b0, 32'h11});
                end
                rx_ready = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk); #1;
                    chk("t4_tx_stall", {tx_ready, sck, busy}, {1'b0, 1'b0, 1'b1});
                end
                tx_stall = 1'b0;
            end
        join
        @(posedge clk); #1;
        chk("t4_counts", {pops, pushes, lasts}, {32'd3, 32'd3, 32'd1});
        chk("t4_pulses", pulses, 24);
        chk("t4_queue_empty", exp_q.size(), 0);

        // 5: zero-length transfer with a word waiting in the TX FIFO
        push_tx(32'h5555_5555);
        go(1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 16'd0);
        wait_last(n);
        chk("t5_latency", n, 1);
        @(posedge clk); #1;
        chk("t5_counts", {busy, pops, pulses, lasts}, {1'b0, 32'd0, 32'd0, 32'd1});
        tx_cnt = tx_idx;

        // 6: reset in the middle of a test-3 style word, then a clean 24-bit transfer
        push_tx(32'hDEAD_BEEF);
        go(1'b1, 1'b1, 1'b0, 8'd3, 2'd3, 16'd1);
        repeat (100) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_reset_vals", {19'd0, busy, last, tx_ready, rx_valid, rx_data, io_out, io_en, sck}, 64'd0);
        st = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("t6_no_push", {pushes, pops}, {32'd0, 32'd1});
        tx_cnt = tx_idx;
        push_tx(32'h12C0_FFEE);
        exp_q.push_back(32'h00C0_FFEE);
        @(posedge clk); #1;
        go(1'b0, 1'b1, 1'b1, 8'd1, 2'd2, 16'd1);
        wait_last(n);
        @(posedge clk); #1;
        chk("t6_after_reset", {pulses, pops, pushes, lasts}, {32'd24, 32'd1, 32'd1, 32'd1});
        chk("t6_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
